// File: rtl/accel_spi_reader.sv
// SPI mode-0 master for an ADXL362-class accelerometer. It does one POWER_CTL write,
// then periodic 5-byte burst reads that publish signed X/Y/Z samples with a valid strobe.
module accel_spi_reader #(
    parameter int CLK_DIV        = 2,
    parameter int STARTUP_CYCLES = 500000,
    parameter int SAMPLE_PERIOD  = 1000000,
    parameter int INVERT_X       = 0,
    parameter int INVERT_Y       = 0
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       spi_miso,
    output logic       spi_sclk,
    output logic       spi_mosi,
    output logic       spi_cs_n,
    output logic [7:0] accel_x,
    output logic [7:0] accel_y,
    output logic [7:0] accel_z,
    output logic       accel_valid,
    output logic       init_done
);

    // A read occupies 16*5*D + D cycles with CS low; 2*D more gives the minimum CS-high time.
    localparam int READ_SLOT   = 16 * 5 * CLK_DIV + 3 * CLK_DIV;
    localparam int PERIOD_EFF  = (SAMPLE_PERIOD < READ_SLOT) ? READ_SLOT : SAMPLE_PERIOD;
    localparam int DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PER_W       = $clog2(PERIOD_EFF);
    localparam int SU_W        = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
    localparam int SU_LAST_INT = (STARTUP_CYCLES > 0) ? STARTUP_CYCLES - 1 : 0;

    localparam logic [DIV_W-1:0] DIV_LAST       = DIV_W'(CLK_DIV - 1);
    localparam logic [PER_W-1:0] PER_LAST       = PER_W'(PERIOD_EFF - 1);
    localparam logic [PER_W-1:0] PER_AFTER_INIT = PER_W'(PERIOD_EFF - 2 * CLK_DIV);
    localparam logic [SU_W-1:0]  SU_LAST        = SU_W'(SU_LAST_INT);

    localparam logic [39:0] INIT_FRAME    = {8'h0A, 8'h2D, 8'h02, 16'h0000};
    localparam logic [39:0] READ_FRAME    = {8'h0B, 8'h08, 24'h000000};
    localparam logic [5:0]  INIT_LAST_BIT = 6'd23;
    localparam logic [5:0]  READ_LAST_BIT = 6'd39;

    typedef enum logic [2:0] {
        ST_STARTUP   = 3'd0,
        ST_INIT_XFER = 3'd1,
        ST_GAP       = 3'd2,
        ST_READ_XFER = 3'd3,
        ST_LOAD      = 3'd4
    } state_t;

    state_t           state_r;
    logic [SU_W-1:0]  startup_cnt_r;
    logic [PER_W-1:0] period_cnt_r;
    logic [DIV_W-1:0] div_cnt_r;
    logic [5:0]       bit_cnt_r;
    logic             tail_r;
    logic [38:0]      tx_r;
    logic [23:0]      rx_r;

    logic [5:0]       last_bit_s;
    logic [7:0]       x_load_s;
    logic [7:0]       y_load_s;

    // Two's-complement negate; -128 has no positive counterpart and clips to +127.
    function automatic logic [7:0] neg_sat(input logic [7:0] raw);
        logic [7:0] res;
        if (raw == 8'h80) begin
            res = 8'h7F;
        end else begin
            res = 8'h00 - raw;
        end
        return res;
    endfunction

    // Last bit index of the transaction in flight.
    always_comb begin
        last_bit_s = READ_LAST_BIT;
        if (state_r == ST_INIT_XFER) begin
            last_bit_s = INIT_LAST_BIT;
        end else begin
            last_bit_s = READ_LAST_BIT;
        end
    end

    // Orientation correction of the captured X/Y bytes.
    always_comb begin
        x_load_s = rx_r[23:16];
        y_load_s = rx_r[15:8];
        if (INVERT_X != 0) begin
            x_load_s = neg_sat(rx_r[23:16]);
        end else begin
            x_load_s = rx_r[23:16];
        end
        if (INVERT_Y != 0) begin
            y_load_s = neg_sat(rx_r[15:8]);
        end else begin
            y_load_s = rx_r[15:8];
        end
    end

    // Sequencer: startup wait, SPI bit engine, sample load and read scheduling.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_r       <= ST_STARTUP;
            startup_cnt_r <= {SU_W{1'b0}};
            period_cnt_r  <= {PER_W{1'b0}};
            div_cnt_r     <= {DIV_W{1'b0}};
            bit_cnt_r     <= 6'd0;
            tail_r        <= 1'b0;
            tx_r          <= 39'd0;
            rx_r          <= 24'd0;
            spi_sclk      <= 1'b0;
            spi_mosi      <= 1'b0;
            spi_cs_n      <= 1'b1;
            accel_x       <= 8'h00;
            accel_y       <= 8'h00;
            accel_z       <= 8'h00;
            accel_valid   <= 1'b0;
            init_done     <= 1'b0;
        end else begin
            accel_valid <= 1'b0;
            // Cycles since the last read start; saturates at the launch point.
            if (period_cnt_r != PER_LAST) begin
                period_cnt_r <= period_cnt_r + PER_W'(1'b1);
            end
            case (state_r)
                ST_STARTUP: begin
                    if (startup_cnt_r == SU_LAST) begin
                        state_r   <= ST_INIT_XFER;
                        spi_cs_n  <= 1'b0;
                        spi_mosi  <= INIT_FRAME[39];
                        tx_r      <= INIT_FRAME[38:0];
                        div_cnt_r <= {DIV_W{1'b0}};
                        bit_cnt_r <= 6'd0;
                        tail_r    <= 1'b0;
                    end else begin
                        startup_cnt_r <= startup_cnt_r + SU_W'(1'b1);
                    end
                end
                ST_INIT_XFER, ST_READ_XFER: begin
                    if (div_cnt_r != DIV_LAST) begin
                        div_cnt_r <= div_cnt_r + DIV_W'(1'b1);
                    end else begin
                        div_cnt_r <= {DIV_W{1'b0}};
                        if (tail_r) begin
                            // CS hold after the final SCLK fall has elapsed.
                            spi_cs_n <= 1'b1;
                            tail_r   <= 1'b0;
                            if (state_r == ST_INIT_XFER) begin
                                init_done    <= 1'b1;
                                period_cnt_r <= PER_AFTER_INIT;
                                state_r      <= ST_GAP;
                            end else begin
                                state_r <= ST_LOAD;
                            end
                        end else if (!spi_sclk) begin
                            spi_sclk <= 1'b1;
                            rx_r     <= {rx_r[22:0], spi_miso};
                        end else begin
                            spi_sclk <= 1'b0;
                            if (bit_cnt_r == last_bit_s) begin
                                tail_r   <= 1'b1;
                                spi_mosi <= 1'b0;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 6'd1;
                                spi_mosi  <= tx_r[38];
                                tx_r      <= {tx_r[37:0], 1'b0};
                            end
                        end
                    end
                end
                ST_LOAD: begin
                    accel_x     <= x_load_s;
                    accel_y     <= y_load_s;
                    accel_z     <= rx_r[7:0];
                    accel_valid <= 1'b1;
                    state_r     <= ST_GAP;
                end
                ST_GAP: begin
                    if (period_cnt_r == PER_LAST) begin
                        state_r      <= ST_READ_XFER;
                        period_cnt_r <= {PER_W{1'b0}};
                        spi_cs_n     <= 1'b0;
                        spi_mosi     <= READ_FRAME[39];
                        tx_r         <= READ_FRAME[38:0];
                        div_cnt_r    <= {DIV_W{1'b0}};
                        bit_cnt_r    <= 6'd0;
                        tail_r       <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_STARTUP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accel_spi_reader.sv
// Directed bench for accel_spi_reader: one instance at a 400-cycle cadence, one with the
// minimum cadence and both axes inverted, each talking to a small mode-0 slave model.
module tb_accel_spi_reader;

    logic       CLK = 1'b0;
    logic       rst_a, rst_b;
    logic       spi_miso_a, spi_sclk_a, spi_mosi_a, spi_cs_n_a;
    logic       spi_miso_b, spi_sclk_b, spi_mosi_b, spi_cs_n_b;
    logic [7:0] accel_x_a, accel_y_a, accel_z_a, accel_x_b, accel_y_b, accel_z_b;
    logic       accel_valid_a, init_done_a, accel_valid_b, init_done_b;

    logic [39:0] reply_a, reply_b;
    logic [39:0] cap_a = 40'd0;
    logic [39:0] last_cap_a = 40'd0;
    int          idx_a = 0, idx_b = 0, nbits_a = 0, last_nbits_a = 0;
    int          last_rise_a = 0, sclk_bad_a = 0, valid_cnt_a = 0, cyc = 0;
    logic        sclk_q_a = 1'b0, cs_q_a = 1'b1, sclk_q_b = 1'b0;
    int          n_cmp = 0, n_bad = 0;
    int          n, t_fall, vcnt;

    always #5 CLK = ~CLK;

    accel_spi_reader #(.CLK_DIV(2), .STARTUP_CYCLES(20), .SAMPLE_PERIOD(400),
                       .INVERT_X(0), .INVERT_Y(0)) dut_a (
        .CLK(CLK), .rst(rst_a), .spi_miso(spi_miso_a), .spi_sclk(spi_sclk_a),
        .spi_mosi(spi_mosi_a), .spi_cs_n(spi_cs_n_a), .accel_x(accel_x_a),
        .accel_y(accel_y_a), .accel_z(accel_z_a), .accel_valid(accel_valid_a),
        .init_done(init_done_a));

    accel_spi_reader #(.CLK_DIV(2), .STARTUP_CYCLES(20), .SAMPLE_PERIOD(10),
                       .INVERT_X(1), .INVERT_Y(1)) dut_b (
        .CLK(CLK), .rst(rst_b), .spi_miso(spi_miso_b), .spi_sclk(spi_sclk_b),
        .spi_mosi(spi_mosi_b), .spi_cs_n(spi_cs_n_b), .accel_x(accel_x_b),
        .accel_y(accel_y_b), .accel_z(accel_z_b), .accel_valid(accel_valid_b),
        .init_done(init_done_b));

    assign spi_miso_a = (idx_a < 40) ? reply_a[39 - idx_a] : 1'b0;
    assign spi_miso_b = (idx_b < 40) ? reply_b[39 - idx_b] : 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Slave A: advance MISO on SCLK fall, capture MOSI on SCLK rise, latch the frame at CS rise.
    always @(posedge CLK) begin
        sclk_q_a <= spi_sclk_a;
        cs_q_a   <= spi_cs_n_a;
        if (accel_valid_a) valid_cnt_a <= valid_cnt_a + 1;
        if (spi_cs_n_a) begin
            idx_a <= 0;
            if (!cs_q_a) begin
                last_cap_a   <= cap_a;
                last_nbits_a <= nbits_a;
            end
            cap_a   <= 40'd0;
            nbits_a <= 0;
        end else begin
            if (sclk_q_a && !spi_sclk_a) idx_a <= idx_a + 1;
            if (!sclk_q_a && spi_sclk_a) begin
                cap_a       <= {cap_a[38:0], spi_mosi_a};
                nbits_a     <= nbits_a + 1;
                last_rise_a <= cyc;
                if (nbits_a > 0 && (cyc - last_rise_a) != 4) sclk_bad_a <= sclk_bad_a + 1;
            end
        end
    end

    // Slave B: MISO only.
    always @(posedge CLK) begin
        sclk_q_b <= spi_sclk_b;
        if (spi_cs_n_b) begin
            idx_b <= 0;
        end else if (sclk_q_b && !spi_sclk_b) begin
            idx_b <= idx_b + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic cs_of(input int d);
        if (d == 0) return spi_cs_n_a;
        else return spi_cs_n_b;
    endfunction

    task automatic wait_cs(input int d, input logic lvl, input int limit, input string tag,
                           output int cnt);
        cnt = 0;
        do begin
            @(posedge CLK); #1;
            cnt = cnt + 1;
        end while ((cs_of(d) != lvl) && (cnt < limit));
        check_eq({tag, "_reached"}, 64'(cs_of(d)), 64'(lvl));
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        reply_a = {8'hA5, 8'h5A, 8'h12, 8'hF0, 8'h40};
        reply_b = {8'hAA, 8'h55, 8'h05, 8'h80, 8'h9C};
        repeat (3) @(posedge CLK);
        #1;
        check_eq("rst_cs_n", 64'(spi_cs_n_a), 64'd1);
        check_eq("rst_sclk", 64'(spi_sclk_a), 64'd0);
        check_eq("rst_mosi", 64'(spi_mosi_a), 64'd0);
        check_eq("rst_xyz", 64'({accel_x_a, accel_y_a, accel_z_a}), 64'd0);
        check_eq("rst_valid", 64'(accel_valid_a), 64'd0);
        check_eq("rst_init_done", 64'(init_done_a), 64'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Startup and init write
        wait_cs(0, 1'b0, 100, "startup", n);
        check_eq("startup_len", 64'(n), 64'd20);
        check_eq("init_pre_done", 64'(init_done_a), 64'd0);
        wait_cs(0, 1'b1, 200, "init_end", n);
        check_eq("init_cs_low", 64'(n), 64'd98);
        check_eq("init_done_rise", 64'(init_done_a), 64'd1);
        check_eq("mosi_idle", 64'(spi_mosi_a), 64'd0);
        wait_cs(0, 1'b0, 20, "read1_start", n);
        check_eq("init_to_read", 64'(n), 64'd4);
        t_fall = cyc;
        check_eq("init_frame", 64'(last_cap_a[23:0]), 64'h0A2D02);
        check_eq("init_nbits", 64'(last_nbits_a), 64'd24);

        // Basic read
        wait_cs(0, 1'b1, 300, "read1_end", n);
        check_eq("read_cs_low", 64'(n), 64'd162);
        check_eq("preload_valid", 64'(accel_valid_a), 64'd0);
        check_eq("preload_x", 64'(accel_x_a), 64'd0);
        @(posedge CLK); #1;
        check_eq("load_valid", 64'(accel_valid_a), 64'd1);
        check_eq("load_x", 64'(accel_x_a), 64'h12);
        check_eq("load_y", 64'(accel_y_a), 64'hF0);
        check_eq("load_z", 64'(accel_z_a), 64'h40);
        reply_a = {8'hA5, 8'h5A, 8'h33, 8'h44, 8'h55};
        @(posedge CLK); #1;
        check_eq("valid_one_cycle", 64'(accel_valid_a), 64'd0);
        check_eq("x_hold", 64'(accel_x_a), 64'h12);
        check_eq("read_frame", 64'(last_cap_a), 64'h0B08000000);
        check_eq("read_nbits", 64'(last_nbits_a), 64'd40);
        vcnt = valid_cnt_a;

        // Cadence and stability
        wait_cs(0, 1'b0, 500, "read2_start", n);
        check_eq("period", 64'(cyc - t_fall), 64'd400);
        repeat (100) @(posedge CLK);
        #1;
        check_eq("stable_x", 64'(accel_x_a), 64'h12);
        check_eq("stable_yz", 64'({accel_y_a, accel_z_a}), 64'hF040);
        check_eq("no_extra_valid", 64'(valid_cnt_a), 64'(vcnt));
        wait_cs(0, 1'b1, 300, "read2_end", n);
        @(posedge CLK); #1;
        check_eq("load2_valid", 64'(accel_valid_a), 64'd1);
        check_eq("load2_xyz", 64'({accel_x_a, accel_y_a, accel_z_a}), 64'h334455);
        check_eq("sclk_period", 64'(sclk_bad_a), 64'd0);

        // Inversion and minimum cadence on B
        n = 0;
        do begin
            @(posedge CLK); #1;
            n = n + 1;
        end while (!accel_valid_b && n < 400);
        check_eq("b_valid_seen", 64'(accel_valid_b), 64'd1);
        check_eq("b_inv_x", 64'(accel_x_b), 64'hFB);
        check_eq("b_inv_y_sat", 64'(accel_y_b), 64'h7F);
        check_eq("b_z_raw", 64'(accel_z_b), 64'h9C);
        check_eq("b_init_done", 64'(init_done_b), 64'd1);
        check_eq("b_mosi_idle", 64'(spi_mosi_b), 64'd0);
        reply_b = {8'hAA, 8'h55, 8'h81, 8'h00, 8'h80};
        wait_cs(1, 1'b0, 20, "b_fall", n);
        t_fall = cyc;
        wait_cs(1, 1'b1, 300, "b_rise", n);
        check_eq("b_cs_low", 64'(n), 64'd162);
        wait_cs(1, 1'b0, 20, "b_gap", n);
        check_eq("b_cs_high_gap", 64'(n), 64'd4);
        check_eq("b_period", 64'(cyc - t_fall), 64'd166);
        check_eq("b_inv_x2", 64'(accel_x_b), 64'h7F);
        check_eq("b_inv_y_zero", 64'(accel_y_b), 64'h00);
        check_eq("b_z_raw_80", 64'(accel_z_b), 64'h80);

        // Reset in the middle of byte 3 of a read on A
        wait_cs(0, 1'b1, 500, "a_idle", n);
        wait_cs(0, 1'b0, 500, "read3_start", n);
        repeat (70) @(posedge CLK);
        #1;
        check_eq("mid_read_cs", 64'(spi_cs_n_a), 64'd0);
        vcnt = valid_cnt_a;
        rst_a = 1'b1;
        @(posedge CLK); #1;
        check_eq("mrst_cs_n", 64'(spi_cs_n_a), 64'd1);
        check_eq("mrst_sclk", 64'(spi_sclk_a), 64'd0);
        check_eq("mrst_mosi", 64'(spi_mosi_a), 64'd0);
        check_eq("mrst_xyz", 64'({accel_x_a, accel_y_a, accel_z_a}), 64'd0);
        check_eq("mrst_init_done", 64'(init_done_a), 64'd0);
        check_eq("mrst_valid", 64'(accel_valid_a), 64'd0);
        @(posedge CLK); #1;
        rst_a = 1'b0;
        wait_cs(0, 1'b0, 100, "restart", n);
        check_eq("restart_len", 64'(n), 64'd20);
        wait_cs(0, 1'b1, 200, "reinit_end", n);
        check_eq("reinit_cs_low", 64'(n), 64'd98);
        check_eq("reinit_done", 64'(init_done_a), 64'd1);
        @(posedge CLK); #1;
        check_eq("reinit_frame", 64'(last_cap_a[23:0]), 64'h0A2D02);
        check_eq("mrst_no_valid", 64'(valid_cnt_a), 64'(vcnt));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/accel_spi_reader.md
# accel_spi_reader

SPI master that configures an ADXL362-class 3-axis accelerometer and then continuously burst-reads its 8-bit X/Y/Z data registers. It is the producer side of the `accel_x` / `accel_y` buses consumed by the ball-motion block. Those consumers see stable signed 8-bit samples that change only on a one-cycle `accel_valid` strobe. The block sits between the board accelerometer pins and the game physics logic.

## Interface
Parameters:
- CLK_DIV, 2 — SCLK half-period in CLK cycles (D); minimum value is 1.
- STARTUP_CYCLES, 500000 — CLK cycles from reset release to the start of the init write.
- SAMPLE_PERIOD, 1000000 — CLK cycles from one read's `spi_cs_n` fall to the next read's fall.
- INVERT_X, 0 — when 1, `accel_x` is the negated raw X sample.
- INVERT_Y, 0 — when 1, `accel_y` is the negated raw Y sample.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- spi_miso  in  1  serial data from the sensor.
- spi_sclk  out  1  SPI clock, mode 0 (idles low).
- spi_mosi  out  1  serial data to the sensor, MSB first.
- spi_cs_n  out  1  active-low chip select.
- accel_x  out  8  signed X sample.
- accel_y  out  8  signed Y sample.
- accel_z  out  8  signed Z sample (raw, never inverted).
- accel_valid  out  1  one-cycle pulse when a new sample set is loaded.
- init_done  out  1  goes high after the configuration write completes, then stays high until reset.

## Operation
- Reset values: `spi_sclk`=0, `spi_cs_n`=1, `spi_mosi`=0, `accel_x`/`accel_y`/`accel_z`=0, `accel_valid`=0, `init_done`=0. The FSM enters STARTUP.
- FSM states: STARTUP → INIT_XFER → GAP → READ_XFER → LOAD → GAP → READ_XFER …
- STARTUP: count STARTUP_CYCLES, then go to INIT_XFER.
- INIT_XFER: 3-byte write 0x0A, 0x2D, 0x02 (POWER_CTL = measure mode). MISO is ignored.
- READ_XFER: 5-byte transaction 0x0B, 0x08, then three dummy 0x00 bytes. Bytes 3, 4 and 5 are captured as X, Y and Z.
- LOAD: lasts one cycle. It registers all three axes simultaneously and pulses `accel_valid`.
- GAP: holds `spi_cs_n` high until the next read start time.
- Inversion: when INVERT_x=1, output = −raw in two's complement. A raw value of −128 (0x80) saturates to +127 (0x7F).
- `rst` asserted in any state, including mid-transaction, takes effect on the next CLK edge:
  - all outputs return to their reset values;
  - `spi_cs_n` rises immediately;
  - the partially shifted byte is discarded;
  - startup and the init write are repeated.

## Timing
- Bit framing. Let t0 be the cycle where `spi_cs_n` falls. `spi_mosi` presents bit 7 of byte 0 at t0.
- Bit k (k = 0 … 8N−1):
  - `spi_sclk` is low for cycles [t0+2kD, t0+2kD+D);
  - `spi_sclk` is high for cycles [t0+2kD+D, t0+2kD+2D).
- `spi_mosi` changes only at the start of a low phase (SCLK falling edge, or t0).
- `spi_miso` is sampled on the CLK edge that drives `spi_sclk` 0→1.
- End of transaction:
  - after the last high phase, `spi_sclk` returns low;
  - `spi_cs_n` stays low D more cycles and rises at t0+16ND+D;
  - `spi_mosi` returns to 0.
- Read transaction length (N=5, D=2): `spi_cs_n` is low for 162 cycles.
- Init completion: `init_done` rises in the cycle `spi_cs_n` rises after the init transaction.
- First read: `spi_cs_n` falls 2D cycles after the init write's `spi_cs_n` rise.
- LOAD timing: occurs the cycle after a read's `spi_cs_n` rise. Outputs change on that edge, and `accel_valid` is high for exactly that one cycle.
- Subsequent reads start SAMPLE_PERIOD cycles after the previous read start.
- If SAMPLE_PERIOD < 16·5·D + D + 2D, the next read starts 2D cycles after the previous `spi_cs_n` rise. This guarantees minimum CS-high time.
- Between pulses, `accel_*` are stable.

## Test plan
- Reset and startup. Setup: CLK_DIV=2, STARTUP_CYCLES=20, SAMPLE_PERIOD=400. Release `rst` → `spi_cs_n` stays 1 for 20 cycles. The init write then shifts 0x0A, 0x2D, 0x02 MSB-first with 4-cycle SCLK periods. `init_done` rises when CS rises.
- Basic read. A mode-0 slave model returns X=0x12, Y=0xF0, Z=0x40 → MOSI carries 0x0B, 0x08, 0x00×3. After CS rises, outputs are `accel_x`=0x12, `accel_y`=0xF0, `accel_z`=0x40, with a single-cycle `accel_valid` one cycle after CS rise.
- Read cadence. Successive `spi_cs_n` falls are exactly 400 cycles apart. Setting SAMPLE_PERIOD=10 instead gives a CS-high gap of exactly 4 cycles.
- Inversion. INVERT_X=1, INVERT_Y=1; slave returns X=0x05, Y=0x80 → `accel_x`=0xFB, `accel_y`=0x7F, `accel_z` unchanged.
- Reset mid-read. Assert `rst` during byte 3 of a read → the next cycle shows `spi_cs_n`=1, `spi_sclk`=0, accel outputs 0, `init_done`=0, with no `accel_valid`. After release, startup and the init write repeat.
- Stability. Slave data changes while CS is high → `accel_*` hold the previous values until the next `accel_valid`.
